// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Purpose  : Central hold/flush sequencer for a five-stage pipeline.
//            Resolves load-use stalls, taken-branch flushes and multi-cycle
//            data-memory waits, with a sticky memory-timeout error flag and
//            saturating stall/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 15,   // 1..255 consecutive MEM_WAIT cycles
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_usesRs1,
    input  logic             id_usesRs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memRead,
    input  logic             ex_branchTaken,
    input  logic             mem_memAccess,
    input  logic             dmem_ready,
    output logic             pcWrite,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             memTimeout_err,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [7:0]       c_timeout = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_nxt;
    logic             r_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_load_use;
    logic w_mem_busy;
    logic w_freeze;
    logic w_branch_flush;

    // Hazard detection: a load in EX feeding a source the ID instruction reads.
    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign w_load_use = ex_memRead && (ex_rd != 5'd0) &&
                        ((id_usesRs1 && (id_rs1 == ex_rd)) ||
                         (id_usesRs2 && (id_rs2 == ex_rd)));

    assign w_mem_busy = mem_memAccess && !dmem_ready;

    // Freeze whenever the MEM stage cannot complete, or forever once in ERROR.
    // In MEM_WAIT only dmem_ready matters: the frozen upstream registers keep
    // the other inputs stable.
    assign w_freeze = ((r_state == ST_RUN)      && w_mem_busy)  ||
                      ((r_state == ST_MEM_WAIT) && !dmem_ready) ||
                      (r_state == ST_ERROR);

    // A branch flush applies only when the pipeline is actually advancing.
    assign w_branch_flush = !rst && !w_freeze && ex_branchTaken;

    // Output decode: reset bubbles everything, freeze holds everything and
    // drains MEM/WB, otherwise branch beats load-use (wrong-path ID instr).
    always_comb begin
        pcWrite     = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (rst) begin
            pcWrite     = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (w_freeze) begin
            pcWrite     = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_branchTaken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (w_load_use) begin
            pcWrite     = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    // Next-state and wait-counter logic for the memory-wait sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_mem_busy) begin
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = 8'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = 8'd0;
                end else if (r_wait_cnt == c_timeout) begin
                    w_state_nxt    = ST_ERROR;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            ST_ERROR: begin
                w_state_nxt    = ST_ERROR;
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // State, wait counter and sticky error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_state_nxt == ST_ERROR) begin
                r_err <= 1'b1;
            end
        end
    end

    // Saturating performance counters: stalled cycles and branch flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pcWrite && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_branch_flush && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign memTimeout_err = r_err;
    assign stallCount     = r_stall_cnt;
    assign flushCount     = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_controller
// Purpose  : Directed-vector scoreboard bench for pipeline_hazard_controller.
//            Stimulus pushes hand-derived expectations; a negedge monitor
//            pops and compares them against the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // Expected response kinds
    localparam int K_DEF = 0;   // free-running pipeline
    localparam int K_FRZ = 1;   // memory freeze
    localparam int K_BR  = 2;   // taken-branch flush
    localparam int K_LU  = 3;   // load-use bubble
    localparam int K_RST = 4;   // reset bubble

    typedef struct packed {
        logic             pcw;
        logic [3:0]       en;   // {ifid, idex, exmem, memwb}
        logic [3:0]       fl;   // {ifid, idex, exmem, memwb}
        logic             err;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_usesRs1, id_usesRs2, ex_memRead, ex_branchTaken;
    logic mem_memAccess, dmem_ready;
    logic pcWrite, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic memTimeout_err;
    logic [CNT_W-1:0] stallCount, flushCount;

    exp_t exp_q[$];
    int   id_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   vec_id = 0;
    logic [CNT_W-1:0] t_stall = '0;
    logic [CNT_W-1:0] t_flush = '0;

    pipeline_hazard_controller #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_usesRs1    (id_usesRs1),
        .id_usesRs2    (id_usesRs2),
        .ex_rd         (ex_rd),
        .ex_memRead    (ex_memRead),
        .ex_branchTaken(ex_branchTaken),
        .mem_memAccess (mem_memAccess),
        .dmem_ready    (dmem_ready),
        .pcWrite       (pcWrite),
        .ifid_en       (ifid_en),
        .idex_en       (idex_en),
        .exmem_en      (exmem_en),
        .memwb_en      (memwb_en),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .exmem_flush   (exmem_flush),
        .memwb_flush   (memwb_flush),
        .memTimeout_err(memTimeout_err),
        .stallCount    (stallCount),
        .flushCount    (flushCount)
    );

    always #5 clk = ~clk;

    task automatic clr_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_usesRs1 = 1'b0; id_usesRs2 = 1'b0;
        ex_memRead = 1'b0; ex_branchTaken = 1'b0;
        mem_memAccess = 1'b0; dmem_ready = 1'b0;
    endtask

    // Inputs are already driven; push this cycle's expectation, advance the
    // counter expectations for the next cycle, then move to the next cycle.
    task automatic step(input int kind, input logic err);
        exp_t e;
        e.err = err;
        e.sc  = t_stall;
        e.fc  = t_flush;
        case (kind)
            K_FRZ:   begin e.pcw = 1'b0; e.en = 4'b0000; e.fl = 4'b0001; end
            K_BR:    begin e.pcw = 1'b1; e.en = 4'b1111; e.fl = 4'b1100; end
            K_LU:    begin e.pcw = 1'b0; e.en = 4'b0111; e.fl = 4'b0100; end
            K_RST:   begin e.pcw = 1'b0; e.en = 4'b0000; e.fl = 4'b1111; end
            default: begin e.pcw = 1'b1; e.en = 4'b1111; e.fl = 4'b0000; end
        endcase
        exp_q.push_back(e);
        id_q.push_back(vec_id);
        vec_id++;
        if (kind == K_RST) begin
            t_stall = '0;
            t_flush = '0;
        end else begin
            if (!e.pcw && t_stall != c_cnt_max) t_stall = t_stall + 1'b1;
            if (kind == K_BR && t_flush != c_cnt_max) t_flush = t_flush + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the oldest expectation away from the active edge.
    initial begin
        exp_t e;
        int   id;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                n_cmp++;
                if ({pcWrite, ifid_en, idex_en, exmem_en, memwb_en,
                     ifid_flush, idex_flush, exmem_flush, memwb_flush,
                     memTimeout_err} !== {e.pcw, e.en, e.fl, e.err}) begin
                    n_fail++;
                    $display("FAIL ctrl vec%0d: got pcw=%b en=%b%b%b%b fl=%b%b%b%b err=%b, want pcw=%b en=%b fl=%b err=%b",
                             id, pcWrite, ifid_en, idex_en, exmem_en, memwb_en,
                             ifid_flush, idex_flush, exmem_flush, memwb_flush,
                             memTimeout_err, e.pcw, e.en, e.fl, e.err);
                end
                n_cmp++;
                if ({stallCount, flushCount} !== {e.sc, e.fc}) begin
                    n_fail++;
                    $display("FAIL counters vec%0d: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
                             id, stallCount, flushCount, e.sc, e.fc);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        clr_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(K_RST, 1'b0);
        rst = 1'b0;

        // Idle
        repeat (3) step(K_DEF, 1'b0);

        // Load-use on rs2, then the load has moved on
        ex_memRead = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_usesRs2 = 1'b1;
        step(K_LU, 1'b0);
        ex_memRead = 1'b0;
        step(K_DEF, 1'b0);
        // Load-use on rs1
        clr_inputs();
        ex_memRead = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_usesRs1 = 1'b1;
        step(K_LU, 1'b0);
        // Register matches but the ID instruction does not read it
        id_usesRs1 = 1'b0;
        step(K_DEF, 1'b0);
        // Load to x0 never stalls
        clr_inputs();
        ex_memRead = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_usesRs2 = 1'b1;
        step(K_DEF, 1'b0);

        // Branch with simultaneous load-use: branch wins
        ex_rd = 5'd5; id_rs2 = 5'd5; ex_branchTaken = 1'b1;
        step(K_BR, 1'b0);
        clr_inputs();
        step(K_DEF, 1'b0);

        // Memory wait of 3 frozen cycles, then release
        mem_memAccess = 1'b1; dmem_ready = 1'b0;
        repeat (3) step(K_FRZ, 1'b0);
        dmem_ready = 1'b1;
        step(K_DEF, 1'b0);
        step(K_DEF, 1'b0);       // access completing in RUN: not busy
        clr_inputs();
        step(K_DEF, 1'b0);

        // Freeze beats branch; branch is applied on the release cycle
        mem_memAccess = 1'b1; ex_branchTaken = 1'b1;
        step(K_FRZ, 1'b0);
        step(K_FRZ, 1'b0);
        dmem_ready = 1'b1;
        step(K_BR, 1'b0);
        clr_inputs();
        step(K_DEF, 1'b0);

        // Timeout: MEM_TIMEOUT+1 = 5 frozen cycles, then ERROR
        mem_memAccess = 1'b1; dmem_ready = 1'b0;
        repeat (5) step(K_FRZ, 1'b0);
        step(K_FRZ, 1'b1);
        dmem_ready = 1'b1; ex_branchTaken = 1'b1;
        repeat (14) step(K_FRZ, 1'b1);   // stallCount reaches saturation

        // Reset during ERROR
        rst = 1'b1;
        step(K_RST, 1'b1);
        rst = 1'b0;
        clr_inputs();
        step(K_DEF, 1'b0);

        // Reset during MEM_WAIT
        mem_memAccess = 1'b1; dmem_ready = 1'b0;
        step(K_FRZ, 1'b0);
        step(K_FRZ, 1'b0);
        rst = 1'b1;
        step(K_RST, 1'b0);
        rst = 1'b0;
        clr_inputs();
        step(K_DEF, 1'b0);

        // flushCount saturation
        ex_branchTaken = 1'b1;
        repeat (17) step(K_BR, 1'b0);
        clr_inputs();
        step(K_DEF, 1'b0);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout at %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
